// File: rtl/gen_mem_top.sv
// Single-port word memory with byte-masked writes and a credit-gated read path.
// Reads pass through a fixed-latency pipeline and then an in-order response FIFO.
module gen_mem_top #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RSP_DEPTH  = 2,
    parameter string       IFILE      = ""
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] wmask_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    rerr_o
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    // Elaboration-time guards on parameter legality
    if (DATA_WIDTH < 8 || DATA_WIDTH > 128 || (DATA_WIDTH % 8) != 0) begin : g_bad_dw
        $error("gen_mem_top: DATA_WIDTH must be a multiple of 8 in 8..128");
    end
    if (DEPTH < 1 || 64'(DEPTH) > (64'(1) << ADDR_WIDTH)) begin : g_bad_depth
        $error("gen_mem_top: DEPTH must be in 1..2**ADDR_WIDTH");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("gen_mem_top: RD_LAT must be in 1..4");
    end
    if (RSP_DEPTH < 1 || RSP_DEPTH > 8) begin : g_bad_rsp
        $error("gen_mem_top: RSP_DEPTH must be in 1..8");
    end
    if (IFILE != "") begin : g_ifile
        $warning("gen_mem_top: IFILE preload is left to the memory compiler / backend flow");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  in_range_c;
    logic                  credit_ok_c;
    logic                  rd_acc_c;
    logic                  wr_acc_c;
    logic                  pop_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic                  push_v_c;
    logic [DATA_WIDTH-1:0] push_d_c;
    logic                  push_e_c;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      fcnt_q, fcnt_d;
    logic [PTR_W-1:0]      wp_q, rp_q;
    logic [DATA_WIDTH-1:0] fd_q [RSP_DEPTH];
    logic                  fe_q [RSP_DEPTH];

    assign in_range_c  = {1'b0, addr_i} < (ADDR_WIDTH + 1)'(DEPTH);
    assign pop_c       = rvalid_o & rready_i;
    // A same-cycle pop frees a slot for the read being requested now
    assign credit_ok_c = ({1'b0, cnt_q} - (CNT_W + 1)'(pop_c)) < (CNT_W + 1)'(RSP_DEPTH);
    assign gnt_o       = rst_ni & req_i & (we_i | credit_ok_c);
    assign rd_acc_c    = gnt_o & ~we_i;
    assign wr_acc_c    = gnt_o & we_i;
    assign rd_word_c   = in_range_c ? mem_q[addr_i] : '0;

    // Array is deliberately outside the reset domain so contents survive reset
    always_ff @(posedge clk_i) begin
        if (wr_acc_c && in_range_c) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // The array sample is the first latency stage; extra stages are registered
    if (RD_LAT == 1) begin : g_lat1
        assign push_v_c = rd_acc_c;
        assign push_d_c = rd_word_c;
        assign push_e_c = ~in_range_c;
    end else begin : g_pipe
        logic                  pv_q [RD_LAT-1];
        logic [DATA_WIDTH-1:0] pd_q [RD_LAT-1];
        logic                  pe_q [RD_LAT-1];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < RD_LAT - 1; i++) begin
                    pv_q[i] <= 1'b0;
                    pd_q[i] <= '0;
                    pe_q[i] <= 1'b0;
                end
            end else begin
                pv_q[0] <= rd_acc_c;
                pd_q[0] <= rd_word_c;
                pe_q[0] <= ~in_range_c;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    pv_q[i] <= pv_q[i-1];
                    pd_q[i] <= pd_q[i-1];
                    pe_q[i] <= pe_q[i-1];
                end
            end
        end

        assign push_v_c = pv_q[RD_LAT-2];
        assign push_d_c = pd_q[RD_LAT-2];
        assign push_e_c = pe_q[RD_LAT-2];
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(rd_acc_c) - CNT_W'(pop_c);
        fcnt_d = fcnt_q + CNT_W'(push_v_c) - CNT_W'(pop_c);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            fcnt_q <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            fcnt_q <= fcnt_d;
            if (push_v_c) wp_q <= ptr_inc(wp_q);
            if (pop_c)    rp_q <= ptr_inc(rp_q);
        end
    end

    // Payload storage needs no reset; visibility is qualified by the occupancy count
    always_ff @(posedge clk_i) begin
        if (push_v_c) begin
            fd_q[wp_q] <= push_d_c;
            fe_q[wp_q] <= push_e_c;
        end
    end

    assign rvalid_o = (fcnt_q != '0);
    assign rdata_o  = rvalid_o ? fd_q[rp_q] : '0;
    assign rerr_o   = rvalid_o & fe_q[rp_q];

endmodule

// File: tb/tb_gen_mem_top.sv
// Bench for gen_mem_top: two instances (latency 1 / depth-2 FIFO, latency 3 / depth-4 FIFO)
// driven by directed and random traffic, checked against a transaction-level model.
module tb_gen_mem_top;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 10;
    localparam int unsigned DEP  = 1000;
    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 3;
    localparam int unsigned RSD0 = 2;
    localparam int unsigned RSD1 = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            t;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req    [2];
    logic          we     [2];
    logic          rready [2];
    logic [AW-1:0] addr   [2];
    logic [3:0]    wmask  [2];
    logic [DW-1:0] wdata  [2];
    logic          gnt    [2];
    logic          rvalid [2];
    logic          rerr   [2];
    logic [DW-1:0] rdata  [2];

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            grants = 0;
    logic [DW-1:0] mdl [2][1024];
    rsp_t          exp_q [$];

    always #5 clk = ~clk;

    gen_mem_top #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .RD_LAT(LAT0),
                  .RSP_DEPTH(RSD0), .IFILE("")) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
        .we_i(we[0]), .wmask_i(wmask[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
        .rready_i(rready[0]), .rdata_o(rdata[0]), .rerr_o(rerr[0]));

    gen_mem_top #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .RD_LAT(LAT1),
                  .RSP_DEPTH(RSD1), .IFILE("")) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
        .we_i(we[1]), .wmask_i(wmask[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
        .rready_i(rready[1]), .rdata_o(rdata[1]), .rerr_o(rerr[1]));

    function automatic int lat_of(input int u);
        return (u == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    function automatic int rsd_of(input int u);
        return (u == 0) ? int'(RSD0) : int'(RSD1);
    endfunction

    // One clock cycle on instance u: drive at negedge, check just before the next posedge
    task automatic step(input int u, input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [3:0] m, input logic [DW-1:0] d, input logic rr);
        logic exp_rv;
        logic pop_e;
        logic exp_g;
        int   outst;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; rready[k] = 1'b0;
        end
        req[u] = r; we[u] = w; addr[u] = a; wmask[u] = m; wdata[u] = d; rready[u] = rr;
        #4;
        exp_rv = (exp_q.size() > 0) && (exp_q[0].t + lat_of(u) <= cyc);
        total++;
        if (rvalid[u] !== exp_rv) begin
            bad++;
            $display("FAIL rvalid u%0d cyc%0d: got %b want %b", u, cyc, rvalid[u], exp_rv);
        end
        if (exp_rv) begin
            total++;
            if (rdata[u] !== exp_q[0].data || rerr[u] !== exp_q[0].err) begin
                bad++;
                $display("FAIL rsp u%0d cyc%0d: got %h/%b want %h/%b", u, cyc,
                         rdata[u], rerr[u], exp_q[0].data, exp_q[0].err);
            end
        end
        total++;
        if (rvalid[1-u] !== 1'b0) begin
            bad++;
            $display("FAIL idle_rvalid u%0d cyc%0d: got %b want 0", 1-u, cyc, rvalid[1-u]);
        end
        pop_e = exp_rv && rr;
        outst = exp_q.size() - (pop_e ? 1 : 0);
        exp_g = r && (w || outst < rsd_of(u));
        total++;
        if (gnt[u] !== exp_g) begin
            bad++;
            $display("FAIL gnt u%0d cyc%0d: got %b want %b", u, cyc, gnt[u], exp_g);
        end
        if (pop_e) void'(exp_q.pop_front());
        if (exp_g) begin
            grants++;
            if (w) begin
                if (a < DEP) begin
                    for (int b = 0; b < 4; b++)
                        if (m[b]) mdl[u][a][b*8 +: 8] = d[b*8 +: 8];
                end
            end else begin
                exp_q.push_back('{data: (a < DEP) ? mdl[u][a] : '0, err: (a >= DEP), t: cyc});
            end
        end
        cyc++;
    endtask

    task automatic drain(input int u);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(u, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain u%0d: got %0d pending want 0", u, exp_q.size());
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b1; we[k] = 1'b0; rready[k] = 1'b1;
            addr[k] = '0; wmask[k] = '0; wdata[k] = '0;
        end
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (gnt[k] !== 1'b0 || rvalid[k] !== 1'b0 || rdata[k] !== '0 || rerr[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_outs u%0d: got g%b v%b d%h e%b want all 0", k,
                         gnt[k], rvalid[k], rdata[k], rerr[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) req[k] = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_preload();
        for (int u = 0; u < 2; u++) begin
            for (int a = 0; a < 32; a++) step(u, 1'b1, 1'b1, AW'(a), 4'hF, $urandom, 1'b1);
            step(u, 1'b1, 1'b1, AW'(488), 4'hF, $urandom, 1'b1);
            step(u, 1'b1, 1'b1, AW'(999), 4'hF, $urandom, 1'b1);
        end
    endtask

    task automatic test_write_read();
        step(0, 1'b1, 1'b1, AW'(5), 4'hF, 32'hDEADBEEF, 1'b1);
        step(0, 1'b1, 1'b0, AW'(5), 4'h0, '0, 1'b1);
        step(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        total++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hDEADBEEF || rerr[0] !== 1'b0) begin
            bad++;
            $display("FAIL wr_rd: got v%b %h e%b want v1 deadbeef e0", rvalid[0], rdata[0], rerr[0]);
        end
        drain(0);
    endtask

    task automatic test_byte_mask();
        step(0, 1'b1, 1'b1, AW'(7), 4'hF, 32'h11223344, 1'b1);
        step(0, 1'b1, 1'b1, AW'(7), 4'h2, 32'hAABBCCDD, 1'b1);
        step(0, 1'b1, 1'b1, AW'(7), 4'h0, 32'h55555555, 1'b1);
        step(0, 1'b1, 1'b0, AW'(7), 4'h0, '0, 1'b1);
        step(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        total++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h1122CC44) begin
            bad++;
            $display("FAIL byte_mask: got v%b %h want v1 1122cc44", rvalid[0], rdata[0]);
        end
        drain(0);
    endtask

    task automatic test_credit();
        step(0, 1'b1, 1'b0, AW'(1), '0, '0, 1'b0);
        step(0, 1'b1, 1'b0, AW'(2), '0, '0, 1'b0);
        step(0, 1'b1, 1'b0, AW'(3), '0, '0, 1'b0);
        total++;
        if (gnt[0] !== 1'b0) begin
            bad++;
            $display("FAIL credit_block: got gnt %b want 0", gnt[0]);
        end
        step(0, 1'b1, 1'b0, AW'(3), '0, '0, 1'b1);
        total++;
        if (gnt[0] !== 1'b1) begin
            bad++;
            $display("FAIL credit_pop_gnt: got gnt %b want 1", gnt[0]);
        end
        step(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        drain(0);
    endtask

    task automatic test_out_of_range();
        step(0, 1'b1, 1'b1, AW'(1000), 4'hF, 32'hFFFFFFFF, 1'b1);
        step(0, 1'b1, 1'b0, AW'(1000), '0, '0, 1'b1);
        step(0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        total++;
        if (rvalid[0] !== 1'b1 || rerr[0] !== 1'b1 || rdata[0] !== '0) begin
            bad++;
            $display("FAIL oor_read: got v%b e%b %h want v1 e1 0", rvalid[0], rerr[0], rdata[0]);
        end
        step(0, 1'b1, 1'b0, AW'(488), '0, '0, 1'b1);
        step(0, 1'b1, 1'b0, AW'(0), '0, '0, 1'b1);
        step(0, 1'b1, 1'b0, AW'(999), '0, '0, 1'b1);
        step(0, 1'b1, 1'b0, AW'(1023), '0, '0, 1'b1);
        drain(0);
    endtask

    task automatic test_stream();
        int g0;
        g0 = grants;
        for (int i = 0; i < 16; i++) step(1, 1'b1, 1'b0, AW'(i), '0, '0, 1'b1);
        total++;
        if (grants - g0 != 16) begin
            bad++;
            $display("FAIL stream_gnt: got %0d grants want 16", grants - g0);
        end
        drain(1);
    endtask

    task automatic test_reset_inflight();
        step(1, 1'b1, 1'b0, AW'(3), '0, '0, 1'b1);
        step(1, 1'b1, 1'b0, AW'(4), '0, '0, 1'b1);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; rready[1] = 1'b1;
        rst_n = 1'b0;
        #1;
        total++;
        if (rvalid[1] !== 1'b0 || gnt[1] !== 1'b0 || rdata[1] !== '0) begin
            bad++;
            $display("FAIL rst_inflight: got v%b g%b %h want 0 0 0", rvalid[1], gnt[1], rdata[1]);
        end
        exp_q.delete();
        @(negedge clk);
        req[1] = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        step(1, 1'b1, 1'b0, AW'(3), '0, '0, 1'b1);
        step(1, 1'b1, 1'b0, AW'(4), '0, '0, 1'b1);
        drain(1);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 300; i++) begin
                case ($urandom_range(0, 7))
                    0:       a = AW'(1000 + $urandom_range(0, 23));
                    1:       a = AW'(999);
                    default: a = AW'($urandom_range(0, 31));
                endcase
                step(u, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a,
                     4'($urandom), $urandom, $urandom_range(0, 3) != 0);
            end
            drain(u);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_write_read();
        test_byte_mask();
        test_credit();
        test_out_of_range();
        test_stream();
        test_reset_inflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
